fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001: Parameter RESET_ADDR, default 32'h0000_0000; the PC value loaded on reset.
REQ-002: Parameter INSTR_NOP, default 32'h0000_0000; the instr_out value while the IF/ID slot is empty.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: hold  input  1  from the hazard unit; freeze the PC and IF/ID outputs this cycle.
REQ-006: flush  input  1  branch taken; squash the IF/ID slot and redirect the PC.
REQ-007: branch_target  input  32  redirect address, sampled when flush=1.
REQ-008: imem_req  output  1  instruction-memory request valid.
REQ-009: imem_addr  output  32  fetch address, equal to the current PC.
REQ-010: imem_ready  input  1  memory returns imem_rdata in this cycle; may stay low for any number of cycles.
REQ-011: imem_rdata  input  32  returned instruction, valid only when imem_req=1 and imem_ready=1.
REQ-012: instr_out  output  32  IF/ID instruction, feeding the decode field split.
REQ-013: pc_out  output  32  address of instr_out.
REQ-014: pc_plus4_out  output  32  pc_out+4, modulo 2^32.
REQ-015: valid_out  output  1  IF/ID slot holds a live instruction.

Function
REQ-016: FSM states: IDLE, FETCH, HELD; an accepted fetch is a cycle with imem_req=1 and imem_ready=1.
REQ-017: IDLE: imem_req=0; next state is FETCH unconditionally, giving one bubble cycle after reset.
REQ-018: FETCH: imem_req=1 and imem_addr=PC; imem_addr stays stable until imem_ready=1 or flush=1.
REQ-019: FETCH with accepted fetch and hold=0: on the next edge IF/ID <= {imem_rdata, PC, PC+4, valid=1}, PC <= PC+4, and the state stays FETCH. Latency is 1 cycle from acceptance to valid_out.
REQ-020: FETCH with accepted fetch and hold=1: imem_rdata and PC go into a one-entry skid buffer, PC <= PC+4, state goes to HELD, and the IF/ID outputs are unchanged.
REQ-021: FETCH with imem_ready=0 and hold=0: on the next edge valid_out <= 0 (a bubble) and instr_out <= INSTR_NOP.
REQ-022: FETCH or HELD with hold=1 and no flush: instr_out, pc_out, pc_plus4_out and valid_out are unchanged.
REQ-023: HELD: imem_req=0; when hold=0, IF/ID <= skid buffer with valid=1 and the state goes to FETCH; while hold=1 the state stays HELD.
REQ-024: Flush has priority over hold, imem_ready and all FSM transitions. On the next edge:
  - PC <= branch_target, the skid buffer is cleared, and the state goes to FETCH;
  - valid_out <= 0 and instr_out <= INSTR_NOP;
  - any imem_rdata returned in the flush cycle is discarded;
  - imem_addr shows branch_target in the following cycle.
REQ-025: PC arithmetic is unsigned 32-bit; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag raised.
REQ-026: branch_target[1:0] is used unmodified; there is no alignment check.
REQ-027: At most one instruction is in flight; imem_req never asserts a new address before the current one is accepted or flushed.

Reset
REQ-028: When rst=1 at an edge: PC <= RESET_ADDR, state <= IDLE, valid_out <= 0, instr_out <= INSTR_NOP, pc_out <= RESET_ADDR, pc_plus4_out <= RESET_ADDR+4, and the skid buffer is cleared.
REQ-029: rst has priority over flush and hold; reset during FETCH or HELD abandons the outstanding request with no output side-effects.
REQ-030: While rst=1, imem_req=0 combinationally.

Verification
REQ-031: Reset then imem_ready tied to 1 -> imem_req low for 1 cycle, then imem_addr 0,4,8; valid_out rises 2 cycles after rst falls, with pc_out=0.
REQ-032: imem_ready low for 3 cycles at address 0x10 -> imem_addr holds 0x10 for 4 cycles; valid_out=0 for 3 cycles; then instr_out=rdata and pc_out=0x10.
REQ-033: hold=1 for 2 cycles coinciding with an accept at 0x8 -> IF/ID frozen for 2 cycles, imem_req low in HELD; after release instr_out=rdata@0x8 and imem_addr=0xC.
REQ-034: flush=1 with branch_target=0x40 together with hold=1 and imem_ready=1 -> next cycle valid_out=0 and imem_addr=0x40; the returned rdata never appears on instr_out.
REQ-035: PC=0xFFFF_FFFC accepted -> pc_plus4_out=0 and next imem_addr=0.
REQ-036: rst asserted in HELD with hold=1 -> next cycle state IDLE, valid_out=0 and pc_out=RESET_ADDR; the buffered instruction never emerges.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage: instruction fetch stage with the IF/ID pipeline register.
//   clk, rst          single clock; synchronous active-high reset
//   hold              freeze PC and IF/ID outputs (hazard unit)
//   flush             branch taken: squash IF/ID, redirect PC to branch_target
//   imem_req/addr     fetch request (one outstanding at most), addr = PC
//   imem_ready/rdata  memory handshake; accept = imem_req & imem_ready
//   instr_out, pc_out, pc_plus4_out, valid_out   IF/ID slot contents
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] INSTR_NOP  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {IDLE, FETCH, HELD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pco_q, pco_d;
  logic [31:0] pc4_q, pc4_d;
  logic        vld_q, vld_d;
  logic        accept;

  assign imem_req     = !rst && (state_q == FETCH);
  assign imem_addr    = pc_q;
  assign accept       = (state_q == FETCH) && imem_ready;
  assign instr_out    = instr_q;
  assign pc_out       = pco_q;
  assign pc_plus4_out = pc4_q;
  assign valid_out    = vld_q;

  always_comb begin
    // Default: everything holds its value.
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pco_d        = pco_q;
    pc4_d        = pc4_q;
    vld_d        = vld_q;

    if (flush) begin
      // Flush beats hold/ready; any rdata returned this cycle is dropped.
      state_d      = FETCH;
      pc_d         = branch_target;
      skid_instr_d = INSTR_NOP;
      skid_pc_d    = RESET_ADDR;
      vld_d        = 1'b0;
      instr_d      = INSTR_NOP;
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (accept) begin
            pc_d = pc_q + 32'd4;
            if (hold) begin
              // Decode is stalled: park the returned word until release.
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_q;
              state_d      = HELD;
            end else begin
              instr_d = imem_rdata;
              pco_d   = pc_q;
              pc4_d   = pc_q + 32'd4;
              vld_d   = 1'b1;
            end
          end else if (!hold) begin
            vld_d   = 1'b0;
            instr_d = INSTR_NOP;
          end
        end
        HELD: begin
          if (!hold) begin
            instr_d      = skid_instr_q;
            pco_d        = skid_pc_q;
            pc4_d        = skid_pc_q + 32'd4;
            vld_d        = 1'b1;
            skid_instr_d = INSTR_NOP;
            skid_pc_d    = RESET_ADDR;
            state_d      = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_ADDR;
      skid_instr_q <= INSTR_NOP;
      skid_pc_q    <= RESET_ADDR;
      instr_q      <= INSTR_NOP;
      pco_q        <= RESET_ADDR;
      pc4_q        <= RESET_ADDR + 32'd4;
      vld_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pco_q        <= pco_d;
      pc4_q        <= pc4_d;
      vld_q        <= vld_d;
    end
  end

endmodule
